punc_mem_arbiter: RTL

//  Sequences the single PUnC memory port between two requesters: CPU control unit (cpu_*) and debug/loader port (dbg_*).

---
 rtl/punc_mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/punc_mem_arbiter.sv
// PUnC memory port arbiter: sequences one memory access at a time between the
// CPU control unit (cpu_*) and the debug/loader port (dbg_*), using a
// req/ack handshake per requester and fixed-latency read capture.
// Optional feature macro: PUNC_ARB_RR_EN
//   defined   -> round-robin on a simultaneous request (first tie after reset goes to CPU)
//   undefined -> fixed priority, debug wins every tie
module punc_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arbState_t;

  arbState_t           r_state;
  arbState_t           w_stateNext;
  logic [1:0]          r_waitCnt;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [DATA_W-1:0]   r_memWdata;
  logic                r_grantId;
  logic [DATA_W-1:0]   r_cpuRdata;
  logic [DATA_W-1:0]   r_dbgRdata;
  logic                w_anyReq;
  logic                w_pickDbg;
  logic                w_grant;
  logic                w_capture;

  assign w_anyReq  = i_cpu_req | i_dbg_req;
  assign w_grant   = (r_state == IDLE) && w_anyReq;
  assign w_capture = (r_state == WAIT) && (r_waitCnt == 2'd0);

`ifdef PUNC_ARB_RR_EN
  logic r_lastGrant;

  // On a tie, grant whichever requester was not served last
  always_comb begin
    w_pickDbg = i_dbg_req & (~i_cpu_req | ~r_lastGrant);
  end

  // Remember the owner of every grant; reset points at debug so the first tie goes to CPU
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lastGrant <= 1'b1;
    end else if (w_grant) begin
      r_lastGrant <= w_pickDbg;
    end
  end
`else
  // Fixed priority: debug wins whenever it is requesting
  always_comb begin
    w_pickDbg = i_dbg_req;
  end
`endif

  // Next-state logic for the IDLE -> ACCESS -> (WAIT) -> DONE sequence
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_stateNext = ACCESS;
      ACCESS:  w_stateNext = r_memWe ? DONE : WAIT;
      WAIT:    if (r_waitCnt == 2'd0) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // State register and read-latency countdown; reset drops any in-flight access
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_waitCnt <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == ACCESS) begin
        r_waitCnt <= 2'(RD_LAT - 1);
      end else if ((r_state == WAIT) && (r_waitCnt != 2'd0)) begin
        r_waitCnt <= r_waitCnt - 2'd1;
      end
    end
  end

  // Latch the winner's command at grant time; values hold while idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_grantId  <= 1'b0;
    end else if (w_grant) begin
      r_grantId  <= w_pickDbg;
      r_memWe    <= w_pickDbg ? i_dbg_we    : i_cpu_we;
      r_memAddr  <= w_pickDbg ? i_dbg_addr  : i_cpu_addr;
      r_memWdata <= w_pickDbg ? i_dbg_wdata : i_cpu_wdata;
    end
  end

  // Capture read data into the winner's register only; the other side is untouched
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpuRdata <= '0;
      r_dbgRdata <= '0;
    end else if (w_capture) begin
      if (r_grantId) begin
        r_dbgRdata <= i_mem_rdata;
      end else begin
        r_cpuRdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_en    = (r_state == ACCESS);
  assign o_mem_we    = r_memWe;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;
  assign o_busy      = (r_state != IDLE);
  assign o_grant_id  = r_grantId;
  assign o_cpu_ack   = (r_state == DONE) && !r_grantId;
  assign o_dbg_ack   = (r_state == DONE) &&  r_grantId;
  assign o_cpu_rdata = r_cpuRdata;
  assign o_dbg_rdata = r_dbgRdata;

endmodule
